// File: rtl/arb_pkg.sv
// Shared types and default widths for the memory bus arbiter.
// Latency: none (declarations only).
// Backpressure: n/a.
package arb_pkg;

  localparam int ARB_ADDR_W = 64;
  localparam int ARB_DATA_W = 64;

  // Arbiter transaction phase
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } arb_state_t;

  // Requester identity: instruction fetch or memory stage
  typedef enum logic {
    ARB_I = 1'b0,
    ARB_D = 1'b1
  } arb_id_t;

endpackage

// File: rtl/arb_picker.sv
// Chooses which pending requester receives the next grant.
// Latency: purely combinational.
// Backpressure: none; MEM_ARB_RR_EN selects round-robin, otherwise dbus wins.
module arb_picker
  import arb_pkg::*;
(
  input  logic i_valid,
  input  logic d_valid,
  input  logic rr_last,
  output logic any,
  output logic pick
);

  assign any = i_valid | d_valid;

`ifdef MEM_ARB_RR_EN
  // On contention hand the grant to whoever was not served last
  always_comb begin
    pick = ARB_D;
    if (i_valid && d_valid) begin
      pick = (rr_last == ARB_I) ? ARB_D : ARB_I;
    end else if (i_valid) begin
      pick = ARB_I;
    end
  end
`else
  // Fixed priority: the memory stage holds the older instruction
  logic w_unused_rr;
  assign w_unused_rr = rr_last;
  assign pick = d_valid ? ARB_D : ARB_I;
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one downstream memory port between ibus and dbus, grant locked per transaction.
// Latency: one IDLE grant cycle, then request; data_ok is same-cycle with m_resp_valid.
// Backpressure: m_valid and its fields hold until m_ready; MEM_ARB_RR_EN enables round-robin.
module mem_bus_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int DATA_W = ARB_DATA_W
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                i_valid,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_data_ok,
  output logic [DATA_W-1:0]   i_data,
  input  logic                d_valid,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W/8-1:0] d_strobe,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_data_ok,
  output logic [DATA_W-1:0]   d_data,
  output logic                m_valid,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W/8-1:0] m_strobe,
  output logic [DATA_W-1:0]   m_wdata,
  input  logic                m_ready,
  input  logic                m_resp_valid,
  input  logic [DATA_W-1:0]   m_rdata
);

  arb_state_t r_state;
  arb_id_t    r_gnt;
  logic       w_rr_last;
  logic       w_any;
  logic       w_pick;
  logic       w_req;
  logic       w_complete;
  logic       w_gnt_d;

`ifdef MEM_ARB_RR_EN
  arb_id_t    r_rr_last;
  assign w_rr_last = r_rr_last;
`else
  assign w_rr_last = ARB_I;
`endif

  arb_picker u_picker (
    .i_valid (i_valid),
    .d_valid (d_valid),
    .rr_last (w_rr_last),
    .any     (w_any),
    .pick    (w_pick)
  );

  assign w_req   = (r_state == REQ);
  assign w_gnt_d = (r_gnt == ARB_D);

  // A response only counts once the request has been (or is being) accepted
  assign w_complete = (w_req && m_ready && m_resp_valid) ||
                      ((r_state == WAIT) && m_resp_valid);

  // Transaction FSM: grant in IDLE, present in REQ, await response in WAIT
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state   <= IDLE;
      r_gnt     <= ARB_D;
`ifdef MEM_ARB_RR_EN
      r_rr_last <= ARB_I;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_gnt   <= arb_id_t'(w_pick);
            r_state <= REQ;
          end
        end
        REQ: begin
          if (m_ready) begin
            r_state <= m_resp_valid ? IDLE : WAIT;
          end
        end
        WAIT: begin
          if (m_resp_valid) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
`ifdef MEM_ARB_RR_EN
      if (w_complete) begin
        r_rr_last <= r_gnt;
      end
`endif
    end
  end

  // Downstream request fields come straight from the granted requester's held inputs
  assign m_valid  = w_req;
  assign m_addr   = !w_req ? '0 : (w_gnt_d ? d_addr : i_addr);
  assign m_strobe = (w_req && w_gnt_d) ? d_strobe : '0;
  assign m_wdata  = (w_req && w_gnt_d) ? d_wdata  : '0;

  // Route the response to its owner; a requester that dropped valid gets nothing
  assign i_data_ok = w_complete && !w_gnt_d && i_valid;
  assign d_data_ok = w_complete &&  w_gnt_d && d_valid;
  assign i_data    = i_data_ok ? m_rdata : '0;
  assign d_data    = d_data_ok ? m_rdata : '0;

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

- Shares one downstream memory port between the instruction-fetch requester (ibus) and the memory-stage requester (dbus).
- Sits between the pipeline's fetch and memory stages and the cache/bus interface.
- Arbitrates when both requesters are pending and locks the grant for one full transaction (accept plus response).
- Returns each response only to the requester that owns it.

## Interface
Parameters:
- ADDR_W, 64, address width
- DATA_W, 64, data width; strobe width is DATA_W/8

Ports:
- clk  in  1  clock; all state updates on the rising edge
- resetn  in  1  synchronous, active-low reset
- i_valid  in  1  fetch request pending; held high and stable until i_data_ok
- i_addr  in  ADDR_W  fetch address
- i_data_ok  out  1  one-cycle pulse; i_data is valid
- i_data  out  DATA_W  fetch read data
- d_valid  in  1  memory-stage request pending; held high and stable until d_data_ok
- d_addr  in  ADDR_W  data address
- d_strobe  in  DATA_W/8  byte write enables; 0 means read
- d_wdata  in  DATA_W  store data
- d_data_ok  out  1  one-cycle pulse; d_data is valid (reads), or the store is complete
- d_data  out  DATA_W  load read data
- m_valid  out  1  downstream request valid
- m_addr  out  ADDR_W  downstream address
- m_strobe  out  DATA_W/8  downstream byte enables; always 0 for fetch
- m_wdata  out  DATA_W  downstream store data
- m_ready  in  1  downstream accepts the request in this cycle
- m_resp_valid  in  1  downstream response in this cycle
- m_rdata  in  DATA_W  downstream read data

## Operation
- FSM states:
  - IDLE: no grant.
  - REQ: request presented downstream, not yet accepted.
  - WAIT: request accepted, response outstanding.
- IDLE:
  - If either valid is high, register the grant (gnt = I or D) and go to REQ.
  - If both are high, default policy gives dbus priority, because it carries the older instruction.
- REQ:
  - m_valid=1; m_addr/m_strobe/m_wdata are muxed from the granted requester's live inputs.
  - On m_ready with no m_resp_valid: go to WAIT.
  - On m_ready with m_resp_valid in the same cycle: complete and go to IDLE.
- WAIT:
  - m_valid=0.
  - On m_resp_valid: complete and go to IDLE.
- Complete:
  - Pulse the granted requester's data_ok combinationally in the same cycle as m_resp_valid.
  - Drive its data = m_rdata. The other requester's data_ok stays 0.
- m_resp_valid outside a granted accepted transaction is ignored.
- Requester valid dropping mid-transaction is a protocol violation. The arbiter still completes downstream, then suppresses data_ok if the requester's valid is low at completion.
- After completion the FSM always passes through IDLE for one cycle before the next grant, so the priority decision is re-evaluated.
- Reset values:
  - state=IDLE, gnt=D, rr_last=I.
  - All outputs are 0: m_valid, m_addr, m_strobe, m_wdata, i/d_data_ok, i/d_data.
- Reset mid-transaction: abandon immediately; any later m_resp_valid is ignored until a new accept.

## Timing
- Request high at cycle 0 (from IDLE): m_valid at cycle 1.
- Earliest data_ok is cycle 1, when m_ready and m_resp_valid are both high at cycle 1.
- Fixed overhead is 1 cycle (the IDLE grant cycle) per transaction.
- Back-to-back requests from the same requester: the next m_valid comes 2 cycles after the previous data_ok.
- m_valid is held with stable fields until m_ready; a downstream stall of any length is tolerated.
- Outputs i/d_data_ok are combinational from m_resp_valid and state. All other outputs depend only on registered state plus the held requester inputs.

## Configuration
- MEM_ARB_RR_EN defined:
  - When both requesters are pending in IDLE, grant the one not served last (rr_last).
  - rr_last updates on each completion.
- MEM_ARB_RR_EN undefined:
  - Fixed priority, dbus always wins.
  - rr_last logic is absent.

## Structure
- Shared package (arb_pkg) holds:
  - arb_state_t enum {IDLE, REQ, WAIT}
  - arb_id_t enum {ARB_I, ARB_D}
  - ADDR_W/DATA_W defaults
- One sub-module, arb_picker:
  - Combinational.
  - Inputs: i_valid, d_valid, rr_last.
  - Outputs: any, pick.
  - The policy is selected by MEM_ARB_RR_EN inside it.
- The top module holds the FSM, grant register and output muxes.

## Test plan
- Single fetch: i_valid=1 with i_addr=0x8000_0000, m_ready=1 at cycle 1, m_rdata=0x13 with m_resp_valid at cycle 3 -> m_valid only in cycle 1, i_data_ok=1 with i_data=0x13 in cycle 3, d_data_ok=0 throughout.
- Simultaneous requests at cycle 0 (i 0x1000; d 0x2000 store, strobe 0xFF, wdata 0xDEAD) with zero-latency downstream:
  - d served first, m_strobe=0xFF; then i is served, m_strobe=0x00.
  - With MEM_ARB_RR_EN and a d_valid re-request immediately afterward: i is granted before the second d.
- Downstream stall: m_ready=0 for 5 cycles -> m_valid and m_addr are held constant for all 5 cycles; the accept happens on the 6th.
- Same-cycle accept and response: m_ready=1 and m_resp_valid=1 in the first REQ cycle -> data_ok in that cycle, state IDLE the next cycle, no WAIT.
- Reset mid-WAIT: resetn=0 for one cycle during WAIT, then m_resp_valid=1 -> no data_ok pulse and all outputs 0 after the reset edge.
- Stray response: m_resp_valid=1 in IDLE -> no data_ok pulse.
